// File: rtl/receiver_pkg.sv
// Shared receiver definitions: channel indices, capture FSM states and default
// pulse-acceptance limits for the PWM capture scheduler.
package receiver_pkg;

  localparam int unsigned N_CH_DEF       = 7;
  localparam int unsigned CH_AUX1        = 0;
  localparam int unsigned CH_AUX2        = 1;
  localparam int unsigned CH_MODE        = 2;
  localparam int unsigned CH_THROTTLE    = 3;
  localparam int unsigned CH_YAW         = 4;
  localparam int unsigned CH_ROLL        = 5;
  localparam int unsigned CH_PITCH       = 6;

  localparam int unsigned MIN_US_DEF     = 800;
  localparam int unsigned MAX_US_DEF     = 2200;
  localparam int unsigned TIMEOUT_US_DEF = 25000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_PUBLISH,
    ST_NEXT
  } state_e;

  function automatic logic [2:0] next_ch(input logic [2:0] ch, input int unsigned n_ch);
    return (ch == 3'(n_ch - 1)) ? 3'd0 : ch + 3'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_scheduler_if.sv
// Receiver-pin and measurement-result bundle of the PWM capture scheduler.
// master = capture block, slave = pin source / result consumer.
interface pwm_capture_scheduler_if #(
  parameter int unsigned N_CH = 7,
  parameter int unsigned W_US = 12
);
  logic            enable;
  logic [N_CH-1:0] pwm_in;
  logic [W_US-1:0] width_us;
  logic [2:0]      width_ch;
  logic            width_valid;
  logic            clamped;
  logic [N_CH-1:0] lost;
  logic            busy;

  modport master (
    input  enable, pwm_in,
    output width_us, width_ch, width_valid, clamped, lost, busy
  );

  modport slave (
    output enable, pwm_in,
    input  width_us, width_ch, width_valid, clamped, lost, busy
  );
endinterface

// File: rtl/pwm_capture_scheduler_sync_edge.sv
// Two-flop synchronizer for one asynchronous PWM pin, with rise/fall
// detection on the synchronized level.
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pulse_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pulse_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;
endmodule

// File: rtl/pwm_capture_scheduler.sv
// Round-robin PWM pulse-width capture: one shared microsecond counter visits
// each receiver channel in turn, publishes widths and flags lost channels.
module pwm_capture_scheduler
  import receiver_pkg::*;
#(
  parameter int unsigned N_CH         = N_CH_DEF,
  parameter int unsigned TICKS_PER_US = 38,
  parameter int unsigned W_US         = 12,
  parameter int unsigned MIN_US       = MIN_US_DEF,
  parameter int unsigned MAX_US       = MAX_US_DEF,
  parameter int unsigned TIMEOUT_US   = TIMEOUT_US_DEF
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  pwm_capture_scheduler_if.master   bus
);
  localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int unsigned VW = $clog2(TIMEOUT_US + 1);

  logic [N_CH-1:0] pwm, lvl, rise, fall;

  assign pwm = bus.pwm_in;

  pwm_sync_edge u_sync [N_CH-1:0] (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .pulse_i (pwm),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [VW-1:0]   visit_q, visit_d;
  logic [W_US-1:0] width_q, width_d;
  logic [2:0]      ch_q, ch_d;
  logic [W_US-1:0] out_us_q, out_us_d;
  logic [2:0]      out_ch_q, out_ch_d;
  logic            valid_q, valid_d;
  logic            clamped_q, clamped_d;
  logic [N_CH-1:0] lost_q, lost_d;

  logic us_tick, timeout, visiting;

  assign us_tick  = (presc_q == PW'(TICKS_PER_US - 1));
  assign timeout  = (visit_q == VW'(TIMEOUT_US));
  assign visiting = (state_q == ST_ARM) || (state_q == ST_WAIT_RISE) || (state_q == ST_MEASURE);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      visit_q   <= '0;
      width_q   <= '0;
      ch_q      <= '0;
      out_us_q  <= '0;
      out_ch_q  <= '0;
      valid_q   <= 1'b0;
      clamped_q <= 1'b0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      visit_q   <= visit_d;
      width_q   <= width_d;
      ch_q      <= ch_d;
      out_us_q  <= out_us_d;
      out_ch_q  <= out_ch_d;
      valid_q   <= valid_d;
      clamped_q <= clamped_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = us_tick ? '0 : presc_q + PW'(1);
    visit_d   = visit_q;
    width_d   = width_q;
    ch_d      = ch_q;
    out_us_d  = out_us_q;
    out_ch_d  = out_ch_q;
    valid_d   = 1'b0;
    clamped_d = clamped_q;
    lost_d    = lost_q;

    if (visiting && us_tick && !timeout) visit_d = visit_q + VW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_ARM;
          visit_d = '0;
        end
      end
      ST_ARM: begin
        if (timeout) begin
          lost_d[ch_q] = 1'b1;
          state_d      = ST_NEXT;
        end else if (!lvl[ch_q]) begin
          state_d = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: begin
        if (timeout) begin
          lost_d[ch_q] = 1'b1;
          state_d      = ST_NEXT;
        end else if (rise[ch_q]) begin
          state_d = ST_MEASURE;
          width_d = '0;
          presc_d = '0;
        end
      end
      ST_MEASURE: begin
        // The tick coinciding with the falling edge still counts, so the
        // width seen in PUBLISH covers every full microsecond of the pulse.
        if (us_tick && (width_q != '1)) width_d = width_q + W_US'(1);
        if (fall[ch_q]) begin
          state_d = ST_PUBLISH;
        end else if (timeout) begin
          lost_d[ch_q] = 1'b1;
          state_d      = ST_NEXT;
        end
      end
      ST_PUBLISH: begin
        if (width_q < W_US'(MIN_US)) begin
          lost_d[ch_q] = 1'b1;
        end else begin
          out_us_d     = (width_q > W_US'(MAX_US)) ? W_US'(MAX_US) : width_q;
          clamped_d    = (width_q > W_US'(MAX_US));
          out_ch_d     = ch_q;
          valid_d      = 1'b1;
          lost_d[ch_q] = 1'b0;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        ch_d = next_ch(ch_q, N_CH);
        if (bus.enable) begin
          state_d = ST_ARM;
          visit_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.width_us    = out_us_q;
  assign bus.width_ch    = out_ch_q;
  assign bus.width_valid = valid_q;
  assign bus.clamped     = clamped_q;
  assign bus.lost        = lost_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_capture_scheduler.sv
// Directed bench for pwm_capture_scheduler: pulses are driven per channel,
// expected strobes are queued and compared when width_valid fires.
module tb_pwm_capture_scheduler;
  localparam int T       = 2;
  localparam int MAX_US  = 2200;
  localparam int TOUT_US = 2600;

  typedef struct {
    int ch;
    int w;
    int cl;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  int   checks   = 0;
  int   failures = 0;
  int   strobes_seen = 0;
  exp_t sb[$];
  logic [6:0] exp_lost = '0;

  pwm_capture_scheduler_if #(.N_CH(7), .W_US(12)) bus ();

  pwm_capture_scheduler #(
    .N_CH         (7),
    .TICKS_PER_US (T),
    .W_US         (12),
    .MIN_US       (800),
    .MAX_US       (MAX_US),
    .TIMEOUT_US   (TOUT_US)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (bus.width_valid === 1'b1) strobes_seen <= strobes_seen + 1;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_pulse(input int ch, input int us);
    bus.pwm_in[ch] = 1'b1;
    tick(us * T);
    bus.pwm_in[ch] = 1'b0;
  endtask

  task automatic push_exp(input int ch, input int us);
    exp_t e;
    e.ch = ch;
    e.w  = (us > MAX_US) ? MAX_US : us;
    e.cl = (us > MAX_US) ? 1 : 0;
    sb.push_back(e);
    exp_lost[ch] = 1'b0;
  endtask

  task automatic get_strobe(input string tag);
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (bus.width_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_strobe"}, int'(got), 1);
    if (got) begin
      check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_ch"}, int'(bus.width_ch), e.ch);
        check({tag, "_width"}, int'(bus.width_us), e.w);
        check({tag, "_clamped"}, int'(bus.clamped), e.cl);
      end
      @(negedge sys_clk);
      check({tag, "_valid_1cyc"}, int'(bus.width_valid), 0);
    end
    tick(10);
  endtask

  task automatic expect_pulse(input string tag, input int ch, input int us);
    push_exp(ch, us);
    drive_pulse(ch, us);
    get_strobe(tag);
  endtask

  task automatic expect_pulse_drop(input string tag, input int ch, input int us);
    push_exp(ch, us);
    bus.pwm_in[ch] = 1'b1;
    tick(us);
    bus.enable = 1'b0;
    tick(us * T - us);
    bus.pwm_in[ch] = 1'b0;
    get_strobe(tag);
    tick(5);
    check({tag, "_busy_low"}, int'(bus.busy), 0);
  endtask

  task automatic wait_lost(input string tag, input int ch);
    for (int i = 0; i < TOUT_US * T + 200; i++) begin
      @(negedge sys_clk);
      if (bus.lost[ch] === 1'b1) break;
    end
    check(tag, int'(bus.lost[ch]), 1);
    exp_lost[ch] = 1'b1;
  endtask

  initial begin
    int seen;
    bus.enable = 1'b0;
    bus.pwm_in = '0;
    tick(3);
    check("rst_width_us", int'(bus.width_us), 0);
    check("rst_width_ch", int'(bus.width_ch), 0);
    check("rst_valid", int'(bus.width_valid), 0);
    check("rst_clamped", int'(bus.clamped), 0);
    check("rst_lost", int'(bus.lost), 0);
    check("rst_busy", int'(bus.busy), 0);

    rst = 1'b0;
    bus.enable = 1'b1;
    tick(10);
    check("busy_after_enable", int'(bus.busy), 1);
    expect_pulse("pre0", 0, 810);
    expect_pulse("pre1", 1, 810);
    expect_pulse("pre2", 2, 810);

    // Reset while channel 3 is being measured
    bus.pwm_in[3] = 1'b1;
    tick(700 * T);
    rst = 1'b1;
    #1;
    check("midrst_width_us", int'(bus.width_us), 0);
    check("midrst_width_ch", int'(bus.width_ch), 0);
    check("midrst_valid", int'(bus.width_valid), 0);
    check("midrst_clamped", int'(bus.clamped), 0);
    check("midrst_lost", int'(bus.lost), 0);
    check("midrst_busy", int'(bus.busy), 0);
    @(negedge sys_clk);
    bus.pwm_in = '0;
    tick(5);
    rst = 1'b0;
    tick(10);

    for (int c = 0; c < 7; c++) expect_pulse($sformatf("sweep%0d", c), c, 1000 + 100 * c);
    check("sweep_lost", int'(bus.lost), 0);

    expect_pulse("f0", 0, 810);
    expect_pulse("f1", 1, 810);
    wait_lost("stuck_low_lost2", 2);
    check("stuck_low_lostvec", int'(bus.lost), int'(exp_lost));
    tick(10);
    expect_pulse("after_stuck_ch3", 3, 810);
    expect_pulse("clamp_ch4", 4, 2400);

    bus.pwm_in[6] = 1'b1;
    seen = strobes_seen;
    drive_pulse(5, 600);
    tick(10);
    exp_lost[5] = 1'b1;
    check("reject_lost5", int'(bus.lost[5]), 1);
    check("reject_no_strobe", strobes_seen, seen);
    wait_lost("stuck_high_lost6", 6);
    bus.pwm_in[6] = 1'b0;
    check("stuck_high_lostvec", int'(bus.lost), int'(exp_lost));
    tick(10);
    for (int c = 0; c < 5; c++) expect_pulse($sformatf("g%0d", c), c, 810);
    expect_pulse("recover_ch5", 5, 1500);
    check("recover_lostvec", int'(bus.lost), int'(exp_lost));

    expect_pulse_drop("drop_ch6", 6, 810);

    // Enable raised mid-pulse on channel 0: that pulse must be skipped
    seen = strobes_seen;
    bus.pwm_in[0] = 1'b1;
    tick(300 * T);
    bus.enable = 1'b1;
    tick(900 * T);
    bus.pwm_in[0] = 1'b0;
    tick(20);
    check("partial_no_strobe", strobes_seen, seen);
    expect_pulse("partial_full_ch0", 0, 1500);

    expect_pulse_drop("drop_ch1", 1, 1000);
    tick(20);
    bus.enable = 1'b1;
    tick(10);
    expect_pulse("resume_ch2", 2, 1000);
    check("final_lost", int'(bus.lost), int'(exp_lost));
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
